coef_fetch_ctrl: RTL and testbench
==================================

COEF_FETCH_CTRL -- requirements
Module: coef_fetch_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH_A, 12, ROM address width; DEPTH, 120, valid ROM entries (0..DEPTH-1); LEN_W, 8, burst-length width; COEF_W, 16, coefficient width.
REQ-002 SHALL have: clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have: rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have: req_valid  in  2  per-requester request; bit i = requester i.
REQ-005 SHALL have: req_base  in  2*WIDTH_A  start address; slice i = requester i.
REQ-006 SHALL have: req_len  in  2*LEN_W  beats requested; slice i = requester i.
REQ-007 SHALL have: req_ack  out  2  one-cycle pulse when request i is accepted.
REQ-008 SHALL have: req_done  out  2  one-cycle pulse when burst i is complete.
REQ-009 SHALL have: rom_addr  out  WIDTH_A  registered address to the combinational coefficient ROM.
REQ-010 SHALL have: rom_coef  in  COEF_W  ROM data for rom_addr, same cycle.
REQ-011 SHALL have: out_valid  out  1; out_ready  in  1; out_data  out  COEF_W; out_id  out  1 (owning requester); out_last  out  1 (final beat).
REQ-012 SHALL have: busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> STREAM -> FLUSH -> IDLE.
REQ-014 In IDLE with any req_valid, SHALL grant one requester, pulse its req_ack, latch base/len/id, and enter STREAM the next cycle.
REQ-015 Arbitration SHALL be round-robin: if both are requesting, grant the one not granted last; after reset, requester 0 has priority.
REQ-016 Requester SHALL hold req_valid/base/len stable until ack; the block SHALL sample them only in the ack cycle.
REQ-017 In STREAM, rom_addr SHALL equal current address; a beat is issued when the output register is empty or out_ready=1: capture rom_coef into out_data, set out_valid, advance address, decrement remaining.
REQ-018 Address advance SHALL wrap DEPTH-1 -> 0; a base >= DEPTH SHALL be reduced to base-DEPTH once at latch (mod DEPTH).
REQ-019 Latency: ack at cycle T, rom_addr=base from T+1, first out_valid at T+2 (when not stalled).
REQ-020 out_data/out_id/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Issuing the beat with remaining=1 SHALL set out_last and move to FLUSH.
REQ-022 In FLUSH, when out_valid&out_ready&out_last, SHALL pulse req_done[id], clear out_valid, and return to IDLE; new arbitration is allowed from the next cycle.
REQ-023 A req_len=0 grant SHALL produce no beats: ack at T, req_done at T+1, back in IDLE at T+2.
REQ-024 Full throughput SHALL be one beat per cycle with out_ready held high; a burst of N takes N+2 cycles from ack to done.
REQ-025 A request arriving during STREAM/FLUSH SHALL wait; the in-flight burst is never preempted.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, out_valid=0, out_last=0, out_id=0, out_data=0, rom_addr=0, req_ack=0, req_done=0, busy=0, RR pointer to requester 0.
REQ-027 Reset mid-burst SHALL abort silently: no req_done for the aborted burst, and remaining beats are discarded.

Structure
REQ-028 Package coef_fetch_pkg SHALL hold WIDTH_A, DEPTH, LEN_W, COEF_W defaults and the FSM state enum.
REQ-029 Sub-module rr_arb2 (2-way round-robin arbiter, one-hot grant, pointer update on accept) SHALL be used; the ROM stays external.

Verification (bench ROM model returns addr+1)
REQ-030 Req0 base=0 len=4, out_ready=1 -> ack0 at T, data 1,2,3,4 at T+2..T+5, out_last on 4, done0 at T+5.
REQ-031 Req1 base=118 len=4 -> data 119,120,1,2 (wrap), out_id=1.
REQ-032 Both requesting after reset, len=2 each -> req0 served first then req1; repeating the request -> req1 then req0.
REQ-033 Req0 len=3, out_ready low for 3 cycles after first beat -> out_data holds 1, no beat lost or duplicated, sequence 1,2,3.
REQ-034 Req0 len=0 -> ack at T, done at T+1, out_valid never asserted.
REQ-035 rst_n low for 1 cycle mid-burst of len=8 -> all outputs reset values, no done; next request len=2 completes normally.

Source files
------------

// File: rtl/coef_fetch_pkg.sv
// -----------------------------------------------------------------------------
// coef_fetch_pkg
// Shared defaults and types for the coefficient fetch controller.
//   WIDTH_A : ROM address width
//   DEPTH   : number of valid ROM entries (0..DEPTH-1)
//   LEN_W   : burst-length width
//   COEF_W  : coefficient width
//   state_e : controller FSM states
// -----------------------------------------------------------------------------
package coef_fetch_pkg;

    localparam int WIDTH_A = 12;
    localparam int DEPTH   = 120;
    localparam int LEN_W   = 8;
    localparam int COEF_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Map a requester index to its one-hot position on the 2-bit ack/done buses.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a one-hot grant. The priority pointer moves
// to the other requester only when the grant is actually accepted.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (priority -> requester 0)
//   req        : per-requester request
//   accept     : the current grant is being taken this cycle
//   grant      : one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the requester that wins when both are requesting.
    logic ptr_r;
    logic [1:0] grant_s;

    // Grant selection: a lone requester always wins, a tie goes to ptr_r.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

    // Pointer update: after serving requester 0, requester 1 gets priority and vice versa.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (accept && (grant_s != 2'b00)) begin
            ptr_r <= grant_s[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/coef_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// coef_fetch_ctrl
// Serves coefficient bursts from an external combinational ROM to one of two
// requesters, one beat per cycle, through a single output register with a
// valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/base/len  : per-requester request (slice i = requester i)
//   req_ack             : one-cycle pulse in the cycle request i is accepted
//   req_done            : one-cycle pulse when burst i has fully drained
//   rom_addr / rom_coef : registered ROM address, same-cycle ROM data
//   out_valid/ready     : output handshake
//   out_data/id/last    : beat payload, owning requester, final-beat flag
//   busy                : controller is not idle
// -----------------------------------------------------------------------------
module coef_fetch_ctrl #(
    parameter int WIDTH_A = coef_fetch_pkg::WIDTH_A,
    parameter int DEPTH   = coef_fetch_pkg::DEPTH,
    parameter int LEN_W   = coef_fetch_pkg::LEN_W,
    parameter int COEF_W  = coef_fetch_pkg::COEF_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [2*WIDTH_A-1:0] req_base,
    input  logic [2*LEN_W-1:0]   req_len,
    output logic [1:0]           req_ack,
    output logic [1:0]           req_done,
    output logic [WIDTH_A-1:0]   rom_addr,
    input  logic [COEF_W-1:0]    rom_coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COEF_W-1:0]    out_data,
    output logic                 out_id,
    output logic                 out_last,
    output logic                 busy
);

    import coef_fetch_pkg::*;

    localparam logic [WIDTH_A-1:0] DEPTH_A  = WIDTH_A'(DEPTH);
    localparam logic [WIDTH_A-1:0] LAST_A   = WIDTH_A'(DEPTH - 1);
    localparam logic [WIDTH_A-1:0] ADDR_ONE = WIDTH_A'(1);
    localparam logic [LEN_W-1:0]   LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

    state_e state_r, next_state_s;
    logic   busy_r;

    logic [WIDTH_A-1:0] addr_r;
    logic [LEN_W-1:0]   rem_r;
    logic               id_r;

    logic               out_valid_r;
    logic [COEF_W-1:0]  out_data_r;
    logic               out_id_r;
    logic               out_last_r;

    logic [1:0]         gnt_s;
    logic               accept_s;
    logic               issue_s;
    logic               done_s;
    logic [WIDTH_A-1:0] base_sel_s;
    logic [WIDTH_A-1:0] base_mod_s;
    logic [LEN_W-1:0]   len_sel_s;
    logic [WIDTH_A-1:0] addr_next_s;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept_s),
        .grant  (gnt_s)
    );

    // Request slice selection, single mod-DEPTH fold of the base, wrapping address increment.
    always_comb begin
        base_sel_s = gnt_s[1] ? req_base[2*WIDTH_A-1:WIDTH_A] : req_base[WIDTH_A-1:0];
        len_sel_s  = gnt_s[1] ? req_len[2*LEN_W-1:LEN_W]     : req_len[LEN_W-1:0];
        if (base_sel_s >= DEPTH_A) begin
            base_mod_s = base_sel_s - DEPTH_A;
        end else begin
            base_mod_s = base_sel_s;
        end
        if (addr_r == LAST_A) begin
            addr_next_s = {WIDTH_A{1'b0}};
        end else begin
            addr_next_s = addr_r + ADDR_ONE;
        end
    end

    // Next-state logic plus the accept/issue/done strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Ack is suppressed while reset is held so no request is consumed then.
                if (rst_n && (req_valid != 2'b00)) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (rem_r == LEN_ZERO) begin
                    // Zero-length grant: report completion without any beat.
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (!out_valid_r || out_ready) begin
                    issue_s = 1'b1;
                    if (rem_r == LEN_ONE) begin
                        next_state_s = ST_FLUSH;
                    end else begin
                        next_state_s = ST_STREAM;
                    end
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake pulses: ack follows the arbiter grant, done goes to the burst owner.
    always_comb begin
        if (accept_s) begin
            req_ack = gnt_s;
        end else begin
            req_ack = 2'b00;
        end
        if (done_s && rst_n) begin
            req_done = id_to_onehot(id_r);
        end else begin
            req_done = 2'b00;
        end
    end

    // State register and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // Burst context: latched on accept, advanced once per issued beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= {WIDTH_A{1'b0}};
            rem_r  <= LEN_ZERO;
            id_r   <= 1'b0;
        end else if (accept_s) begin
            addr_r <= base_mod_s;
            rem_r  <= len_sel_s;
            id_r   <= gnt_s[1];
        end else if (issue_s) begin
            addr_r <= addr_next_s;
            rem_r  <= rem_r - LEN_ONE;
            id_r   <= id_r;
        end else begin
            addr_r <= addr_r;
            rem_r  <= rem_r;
            id_r   <= id_r;
        end
    end

    // Output register: loads on issue, empties on handshake, otherwise holds its payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {COEF_W{1'b0}};
            out_id_r    <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (issue_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rom_coef;
            out_id_r    <= id_r;
            out_last_r  <= (rem_r == LEN_ONE);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_id_r    <= out_id_r;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_id_r    <= out_id_r;
            out_last_r  <= out_last_r;
        end
    end

    assign rom_addr  = addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_coef_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coef_fetch_ctrl
// Directed bench for coef_fetch_ctrl. The ROM model returns addr+1, so every
// expected coefficient below is hand-derived as (effective address + 1).
// -----------------------------------------------------------------------------
module tb_coef_fetch_ctrl;

    localparam int WA = 12;
    localparam int LW = 8;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [2*WA-1:0]   req_base;
    logic [2*LW-1:0]   req_len;
    logic [1:0]        req_ack;
    logic [1:0]        req_done;
    logic [WA-1:0]     rom_addr;
    logic [CW-1:0]     rom_coef;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_data;
    logic              out_id;
    logic              out_last;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_v [8];

    always #5 clk = ~clk;

    assign rom_coef = CW'(rom_addr) + 16'd1;

    coef_fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_base  (req_base),
        .req_len   (req_len),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .rom_addr  (rom_addr),
        .rom_coef  (rom_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input int base, input int len);
        if (id == 1) begin
            req_base[2*WA-1:WA] = WA'(base);
            req_len[2*LW-1:LW]  = LW'(len);
        end else begin
            req_base[WA-1:0] = WA'(base);
            req_len[LW-1:0]  = LW'(len);
        end
        req_valid[id] = 1'b1;
    endtask

    // Unstalled burst of len>=1 starting in an idle cycle; expected data in exp_v.
    task automatic burst(input int id, input int base, input int len, input int base_eff);
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        set_req(id, base, len);
        #1;
        check_eq("ack", 32'(req_ack), 32'(oh));
        check_eq("busy_idle", 32'(busy), 0);
        step();
        req_valid[id] = 1'b0;
        #1;
        check_eq("rom_addr_first", 32'(rom_addr), base_eff);
        check_eq("busy_stream", 32'(busy), 1);
        check_eq("no_valid_t1", 32'(out_valid), 0);
        for (int k = 0; k < len; k++) begin
            step();
            #1;
            check_eq("beat_valid", 32'(out_valid), 1);
            check_eq("beat_data", 32'(out_data), exp_v[k]);
            check_eq("beat_id", 32'(out_id), id);
            check_eq("beat_last", 32'(out_last), (k == len - 1) ? 1 : 0);
            check_eq("beat_done", 32'(req_done), (k == len - 1) ? 32'(oh) : 0);
            check_eq("no_preempt_ack", 32'(req_ack), 0);
        end
        step();
        #1;
        check_eq("end_valid", 32'(out_valid), 0);
        check_eq("end_busy", 32'(busy), 0);
        check_eq("end_done", 32'(req_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_base  = '0;
        req_len   = '0;
        out_ready = 1'b1;

        // Reset values, and no ack while reset is held even with a request present.
        step();
        step();
        req_valid = 2'b01;
        #1;
        check_eq("rst_ack", 32'(req_ack), 0);
        check_eq("rst_done", 32'(req_done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_rom_addr", 32'(rom_addr), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        step();

        // Both requesting after reset: req0 first, then (req0 repeating) req1, then req0.
        set_req(1, 20, 2);
        exp_v = '{11, 12, 0, 0, 0, 0, 0, 0};
        burst(0, 10, 2, 10);
        set_req(0, 10, 2);
        exp_v = '{21, 22, 0, 0, 0, 0, 0, 0};
        burst(1, 20, 2, 20);
        exp_v = '{11, 12, 0, 0, 0, 0, 0, 0};
        burst(0, 10, 2, 10);

        // Basic burst from requester 0.
        exp_v = '{1, 2, 3, 4, 0, 0, 0, 0};
        burst(0, 0, 4, 0);

        // Requester 1 burst wrapping DEPTH-1 -> 0.
        exp_v = '{119, 120, 1, 2, 0, 0, 0, 0};
        burst(1, 118, 4, 118);

        // Base beyond DEPTH is folded once: 125 -> 5.
        exp_v = '{6, 7, 0, 0, 0, 0, 0, 0};
        burst(0, 125, 2, 5);

        // Back-pressure: out_ready low for 3 cycles after the first beat.
        set_req(0, 0, 3);
        #1;
        check_eq("stall_ack", 32'(req_ack), 32'(2'b01));
        step();
        req_valid = 2'b00;
        #1;
        check_eq("stall_rom_addr0", 32'(rom_addr), 0);
        step();
        out_ready = 1'b0;
        #1;
        check_eq("stall_first_valid", 32'(out_valid), 1);
        check_eq("stall_first_data", 32'(out_data), 1);
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            check_eq("stall_hold_valid", 32'(out_valid), 1);
            check_eq("stall_hold_data", 32'(out_data), 1);
            check_eq("stall_hold_last", 32'(out_last), 0);
            check_eq("stall_hold_addr", 32'(rom_addr), 1);
            check_eq("stall_hold_done", 32'(req_done), 0);
        end
        step();
        out_ready = 1'b1;
        #1;
        check_eq("stall_release_data", 32'(out_data), 1);
        step();
        #1;
        check_eq("stall_beat2_data", 32'(out_data), 2);
        check_eq("stall_beat2_last", 32'(out_last), 0);
        step();
        #1;
        check_eq("stall_beat3_data", 32'(out_data), 3);
        check_eq("stall_beat3_last", 32'(out_last), 1);
        check_eq("stall_done", 32'(req_done), 32'(2'b01));
        step();
        #1;
        check_eq("stall_end_valid", 32'(out_valid), 0);
        check_eq("stall_end_busy", 32'(busy), 0);

        // Zero-length request: ack at T, done at T+1, idle at T+2, no beats.
        set_req(0, 7, 0);
        #1;
        check_eq("zero_ack", 32'(req_ack), 32'(2'b01));
        step();
        req_valid = 2'b00;
        #1;
        check_eq("zero_done", 32'(req_done), 32'(2'b01));
        check_eq("zero_valid_t1", 32'(out_valid), 0);
        check_eq("zero_busy_t1", 32'(busy), 1);
        step();
        #1;
        check_eq("zero_done_t2", 32'(req_done), 0);
        check_eq("zero_valid_t2", 32'(out_valid), 0);
        check_eq("zero_busy_t2", 32'(busy), 0);

        // Reset in the middle of a len=8 burst from requester 1.
        set_req(1, 0, 8);
        #1;
        check_eq("abort_ack", 32'(req_ack), 32'(2'b10));
        step();
        req_valid = 2'b00;
        #1;
        step();
        #1;
        check_eq("abort_beat1", 32'(out_data), 1);
        check_eq("abort_id", 32'(out_id), 1);
        step();
        #1;
        check_eq("abort_beat2", 32'(out_data), 2);
        rst_n = 1'b0;
        #1;
        check_eq("abort_done_in_rst", 32'(req_done), 0);
        step();
        #1;
        check_eq("abort_valid", 32'(out_valid), 0);
        check_eq("abort_last", 32'(out_last), 0);
        check_eq("abort_out_id", 32'(out_id), 0);
        check_eq("abort_out_data", 32'(out_data), 0);
        check_eq("abort_rom_addr", 32'(rom_addr), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_ack0", 32'(req_ack), 0);
        check_eq("abort_done0", 32'(req_done), 0);
        rst_n = 1'b1;
        step();
        #1;
        check_eq("post_rst_valid", 32'(out_valid), 0);
        check_eq("post_rst_done", 32'(req_done), 0);
        check_eq("post_rst_busy", 32'(busy), 0);

        // After reset, requester 0 has priority again; both bursts complete normally.
        set_req(1, 0, 2);
        exp_v = '{4, 5, 0, 0, 0, 0, 0, 0};
        burst(0, 3, 2, 3);
        exp_v = '{1, 2, 0, 0, 0, 0, 0, 0};
        burst(1, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
